// File: rtl/dmem_bus_responder_pkg.sv
// Data-memory bus responder: shared address map, TX_STATUS layout
// and the address decoder used by the RTL and the CPU test software.
package dmem_bus_responder_pkg;

  localparam logic [31:0] ADDR_CYCLE_LO  = 32'h8000_0000;
  localparam logic [31:0] ADDR_CYCLE_HI  = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX_DATA   = 32'h8000_0008;
  localparam logic [31:0] ADDR_TX_STATUS = 32'h8000_000C;
  localparam logic [31:0] ADDR_ERR_ADDR  = 32'h8000_0010;

  localparam int TXS_FULL_BIT  = 0;
  localparam int TXS_EMPTY_BIT = 1;
  localparam int TXS_OVF_BIT   = 2;
  localparam int TXS_CNT_LSB   = 4;
  localparam int TXS_CNT_W     = 5;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_TXD,
    SEL_TXS,
    SEL_ERRA
  } sel_e;

  // aw is log2 of the RAM depth in words
  function automatic sel_e addr_decode(
    input logic [31:0] addr,
    input int unsigned aw
  );
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    addr_decode = SEL_NONE;
    unique case (1'b1)
      ((wa >> (aw + 2)) == 32'd0): addr_decode = SEL_RAM;
      (wa == ADDR_CYCLE_LO):       addr_decode = SEL_CYC_LO;
      (wa == ADDR_CYCLE_HI):       addr_decode = SEL_CYC_HI;
      (wa == ADDR_TX_DATA):        addr_decode = SEL_TXD;
      (wa == ADDR_TX_STATUS):      addr_decode = SEL_TXS;
      (wa == ADDR_ERR_ADDR):       addr_decode = SEL_ERRA;
      default:                     addr_decode = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_responder_if.sv
// CPU data bus plus TX byte stream between the core and the responder.
// Port names match the existing core-side signal names.
interface dmem_bus_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        err;

  modport master (
    output daddr, dwdata, dwe, tx_ready,
    input  drdata, tx_data, tx_valid, err
  );

  modport slave (
    input  daddr, dwdata, dwe, tx_ready,
    output drdata, tx_data, tx_valid, err
  );
endinterface

// File: rtl/dmem_bus_responder_tx_fifo.sv
// Synchronous byte FIFO with simultaneous push/pop; a push into a
// full FIFO is accepted only when a pop frees a slot the same cycle.
module tx_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rp_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wp_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end
endmodule

// File: rtl/dmem_bus_responder.sv
// Single-cycle data bus responder: word RAM, cycle counter,
// TX byte FIFO with status, and a sticky bus-error latch.
module dmem_bus_responder
  import dmem_bus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  dmem_bus_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  sel_e          sel;
  logic [AW-1:0] widx;
  logic [31:0]   mem_q [MEM_WORDS];
  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   erra_q, erra_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          wr, bad_wr, clr_err, clr_ovf;
  logic          push, pop, full, empty;
  logic [CW-1:0] cnt;
  logic [7:0]    head;
  logic [31:0]   status;

  assign sel     = addr_decode(bus.daddr, AW);
  assign widx    = bus.daddr[AW+1:2];
  assign wr      = !reset && (bus.dwe != 4'b0000);
  assign bad_wr  = wr && (sel == SEL_NONE ||
                          sel == SEL_CYC_LO ||
                          sel == SEL_CYC_HI);
  assign clr_err = wr && (sel == SEL_ERRA);
  assign clr_ovf = wr && (sel == SEL_TXS) && bus.dwe[0];
  assign push    = wr && (sel == SEL_TXD) && bus.dwe[0];
  assign pop     = !reset && !empty && bus.tx_ready;

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (bus.dwdata[7:0]),
    .pop_i  (pop),
    .data_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(cnt)
  );

  always_ff @(posedge clk) begin
    if (wr && sel == SEL_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dwe[i]) begin
          mem_q[widx][8*i +: 8] <= bus.dwdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    cyc_d  = cyc_q + 64'd1;
    ovf_d  = ovf_q;
    err_d  = err_q;
    erra_d = erra_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (push && full && !pop) begin
      ovf_d = 1'b1;
    end
    // first error address is kept until software clears err
    if (clr_err) begin
      err_d = 1'b0;
    end else if (bad_wr) begin
      err_d = 1'b1;
      if (!err_q) erra_d = bus.daddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      erra_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
      erra_q <= erra_d;
    end
  end

  always_comb begin
    status = '0;
    status[TXS_FULL_BIT]  = full;
    status[TXS_EMPTY_BIT] = empty;
    status[TXS_OVF_BIT]   = ovf_q;
    status[TXS_CNT_LSB +: TXS_CNT_W] = TXS_CNT_W'(cnt);
  end

  always_comb begin
    bus.drdata = '0;
    unique case (sel)
      SEL_RAM:    bus.drdata = mem_q[widx];
      SEL_CYC_LO: bus.drdata = cyc_q[31:0];
      SEL_CYC_HI: bus.drdata = cyc_q[63:32];
      SEL_TXS:    bus.drdata = status;
      SEL_ERRA:   bus.drdata = erra_q;
      default:    bus.drdata = '0;
    endcase
  end

  assign bus.tx_valid = !empty && !reset;
  assign bus.tx_data  = head;
  assign bus.err      = err_q;
endmodule
